// File: rtl/mont_mul.sv
// ---------------------------------------------------------------------------
// mont_mul -- bit-serial radix-2 Montgomery modular multiplier.
//
// Computes Res_out = A * B * 2^-32 mod Prime on 32-bit operands, one
// multiplier bit per clock. A single operation is issued through the
// in_sig / done handshake; the result is held until the next accepted start.
//
// Optional feature macro: MONT_MUL_OPERAND_REDUCE_EN
//   When defined, a PRE state conditionally subtracts Prime from each operand
//   so full 32-bit operands are accepted (Prime > 2^31 makes one subtraction
//   sufficient). When undefined, the caller guarantees A_i, B_i < Prime.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-low reset
//   in_sig   in   1   start strobe, honoured only in IDLE
//   A_i      in  32   multiplicand
//   B_i      in  32   multiplier
//   Prime    in  32   odd modulus, > 2^31
//   Res_out  out 32   Montgomery product, valid while done = 1, then held
//   busy     out  1   high from the cycle after acceptance through FINAL
//   done     out  1   one-cycle pulse marking Res_out valid
// ---------------------------------------------------------------------------
module mont_mul (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_sig,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   input  logic [31:0] Prime,
   output logic [31:0] Res_out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      ST_IDLE,
`ifdef MONT_MUL_OPERAND_REDUCE_EN
      ST_PRE,
`endif
      ST_CALC,
      ST_FINAL,
      ST_OUT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] p_q, p_d;
   logic [32:0] s_q, s_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] res_q, res_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [33:0] t;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      t       = '0;

      case (state_q)
         ST_IDLE: begin
            if (in_sig) begin
               a_d    = A_i;
               b_d    = B_i;
               p_d    = Prime;
               s_d    = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
`ifdef MONT_MUL_OPERAND_REDUCE_EN
               state_d = ST_PRE;
`else
               state_d = ST_CALC;
`endif
            end
         end

`ifdef MONT_MUL_OPERAND_REDUCE_EN
         // Prime > 2^31 means any 32-bit operand is below 2*Prime, so one
         // conditional subtraction fully reduces it.
         ST_PRE: begin
            if (a_q >= p_q) a_d = a_q - p_q;
            if (b_q >= p_q) b_d = b_q - p_q;
            state_d = ST_CALC;
         end
`endif

         // One radix-2 step: add B when the current A bit is set, then add P
         // if needed to make the sum even so the halving is exact. 34 bits
         // hold S + B + P without overflow while S < 2P.
         ST_CALC: begin
            t = {1'b0, s_q} + (a_q[cnt_q] ? {2'b00, b_q} : 34'd0);
            if (t[0]) t = t + {2'b00, p_q};
            s_d   = t[33:1];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = ST_FINAL;
         end

         // Final reduction compares the full 33-bit S; when S >= P the low
         // 32 bits of the difference are the reduced result.
         ST_FINAL: begin
            if (s_q >= {1'b0, p_q}) res_d = s_q[31:0] - p_q;
            else                    res_d = s_q[31:0];
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_OUT;
         end

         ST_OUT: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign Res_out = res_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
